// File: rtl/read_accum_ctrl.sv
// read_accum_ctrl: start/validate a read burst on an Avalon-MM read master,
// drain the master's show-ahead FIFO and reduce the returned words to one
// result (sum, sum of squares, max or min, all unsigned).
module read_accum_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 22,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       read_addr,
    input  logic [31:0]       size,
    input  logic [1:0]        mode,
    input  logic              read_en,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              busy,
    output logic              overflow,
    output logic              error,
    output logic              control_fixed_location,
    output logic [ADDR_W-1:0] control_read_base,
    output logic [ADDR_W-1:0] control_read_length,
    output logic              control_go,
    input  logic              control_done,
    input  logic [DATA_W-1:0] user_buffer_data,
    input  logic              user_data_available,
    output logic              user_read_buffer
);

    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GO    = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [31:0]        words_r;
    logic [31:0]        beats_r;
    logic [1:0]         mode_r;
    logic [ACC_W-1:0]   acc_r;
    logic               done_seen_r;

    logic [63:0]        len_full_s;
    logic               reject_s;
    logic               pop_s;
    logic [31:0]        beats_next_s;
    logic               finish_s;
    logic [2*DATA_W-1:0] square_s;
    logic [ACC_W-1:0]   data_ext_s;
    logic [ACC_W-1:0]   addend_s;
    logic [ACC_W:0]     sum_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               carry_s;

    assign control_fixed_location = 1'b0;

    // Byte length is computed at 64 bits so that a huge word count cannot
    // wrap into an apparently legal length.
    assign len_full_s = {32'd0, size} * 64'(BYTES);

    // Request validation: empty, too long for the master, or misaligned base.
    always_comb begin
        reject_s = 1'b0;
        if (size == 32'd0) begin
            reject_s = 1'b1;
        end else if (len_full_s > ((64'd1 << ADDR_W) - 64'd1)) begin
            reject_s = 1'b1;
        end else if ((read_addr % 32'(BYTES)) != 32'd0) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Pop only while draining and until the requested word count is reached;
    // surplus FIFO data is left for whoever owns the FIFO next.
    assign pop_s            = (state_r == ST_DRAIN) && user_data_available && (beats_r != words_r);
    assign user_read_buffer = pop_s;
    assign beats_next_s     = beats_r + {31'd0, pop_s};
    assign finish_s         = (beats_next_s == words_r) && (done_seen_r || control_done);

    assign square_s   = {{DATA_W{1'b0}}, user_buffer_data} * {{DATA_W{1'b0}}, user_buffer_data};
    assign data_ext_s = ACC_W'(user_buffer_data);
    assign sum_s      = {1'b0, acc_r} + {1'b0, addend_s};

    // Reduction datapath: next accumulator value and carry-out for one beat.
    always_comb begin
        addend_s   = data_ext_s;
        acc_next_s = acc_r;
        carry_s    = 1'b0;
        case (mode_r)
            2'd0: begin
                addend_s   = data_ext_s;
                acc_next_s = sum_s[ACC_W-1:0];
                carry_s    = sum_s[ACC_W];
            end
            2'd1: begin
                addend_s   = ACC_W'(square_s);
                acc_next_s = sum_s[ACC_W-1:0];
                carry_s    = sum_s[ACC_W];
            end
            2'd2: begin
                if (data_ext_s > acc_r) begin
                    acc_next_s = data_ext_s;
                end else begin
                    acc_next_s = acc_r;
                end
            end
            2'd3: begin
                if (data_ext_s < acc_r) begin
                    acc_next_s = data_ext_s;
                end else begin
                    acc_next_s = acc_r;
                end
            end
            default: begin
                acc_next_s = acc_r;
                carry_s    = 1'b0;
            end
        endcase
    end

    // Control FSM with registered status and master-programming outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r             <= ST_IDLE;
            words_r             <= 32'd0;
            beats_r             <= 32'd0;
            mode_r              <= 2'd0;
            acc_r               <= '0;
            done_seen_r         <= 1'b0;
            result              <= '0;
            result_valid        <= 1'b0;
            busy                <= 1'b0;
            overflow            <= 1'b0;
            error               <= 1'b0;
            control_read_base   <= '0;
            control_read_length <= '0;
            control_go          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    control_go <= 1'b0;
                    if (read_en) begin
                        if (reject_s) begin
                            error        <= 1'b1;
                            result_valid <= 1'b0;
                        end else begin
                            control_read_base   <= read_addr[ADDR_W-1:0];
                            control_read_length <= len_full_s[ADDR_W-1:0];
                            words_r             <= size;
                            mode_r              <= mode;
                            beats_r             <= 32'd0;
                            done_seen_r         <= 1'b0;
                            error               <= 1'b0;
                            overflow            <= 1'b0;
                            result_valid        <= 1'b0;
                            acc_r               <= (mode == 2'd3) ? {ACC_W{1'b1}} : {ACC_W{1'b0}};
                            control_go          <= 1'b1;
                            busy                <= 1'b1;
                            state_r             <= ST_GO;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GO: begin
                    control_go  <= 1'b0;
                    done_seen_r <= done_seen_r | control_done;
                    state_r     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    done_seen_r <= done_seen_r | control_done;
                    if (pop_s) begin
                        acc_r   <= acc_next_s;
                        beats_r <= beats_next_s;
                        if (carry_s) begin
                            overflow <= 1'b1;
                        end else begin
                            overflow <= overflow;
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (finish_s) begin
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    result       <= acc_r;
                    result_valid <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    control_go <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_accum_ctrl.sv
// Directed bench for read_accum_ctrl with a small show-ahead FIFO and
// control_done driver; expected results are hand-computed constants.
module tb_read_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] read_addr = 32'd0;
    logic [31:0] size = 32'd0;
    logic [1:0]  mode = 2'd0;
    logic        read_en = 1'b0;
    logic [31:0] result;
    logic        result_valid, busy, overflow, error, control_fixed_location;
    logic [21:0] control_read_base, control_read_length;
    logic        control_go;
    logic        control_done = 1'b0;
    logic [15:0] user_buffer_data = 16'd0;
    logic        user_data_available = 1'b0;
    logic        user_read_buffer;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fifo_data [0:15];
    int          fifo_n = 0;

    read_accum_ctrl #(.DATA_W(16), .ADDR_W(22), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .read_addr(read_addr), .size(size), .mode(mode),
        .read_en(read_en), .result(result), .result_valid(result_valid), .busy(busy),
        .overflow(overflow), .error(error), .control_fixed_location(control_fixed_location),
        .control_read_base(control_read_base), .control_read_length(control_read_length),
        .control_go(control_go), .control_done(control_done),
        .user_buffer_data(user_buffer_data), .user_data_available(user_data_available),
        .user_read_buffer(user_read_buffer)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input int n);
        fifo_data[0] = a; fifo_data[1] = b; fifo_data[2] = c; fifo_data[3] = d;
        fifo_data[4] = 16'h0009; fifo_data[5] = 16'h000A;
        fifo_n = n;
    endtask

    // One full transaction; done_off places control_done relative to the last pop.
    task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] sz,
                          input logic [1:0] md, input bit gaps, input int done_off, input bit poke,
                          input logic [31:0] exp_res, input logic exp_ovf, input logic [21:0] exp_len);
        int  last_pop, done_cyc, exp_valid, popped, seen;
        bit  pop, extra_go;
        read_addr = addr; size = sz; mode = md; read_en = 1'b1;
        tick();
        read_en = 1'b0;
        last_pop  = 2 + (gaps ? 2 : 1) * (int'(sz) - 1);
        done_cyc  = last_pop + done_off;
        exp_valid = ((last_pop > done_cyc) ? last_pop : done_cyc) + 2;
        popped = 0; seen = 0; extra_go = 1'b0;
        chk({tag, " go"},        64'(control_go),   64'(1'b1));
        chk({tag, " busy_go"},   64'(busy),         64'(1'b1));
        chk({tag, " err_clr"},   64'(error),        64'(1'b0));
        chk({tag, " rv_clr"},    64'(result_valid), 64'(1'b0));
        for (int c = 1; c < 300; c++) begin
            if (result_valid) begin
                seen = c;
                break;
            end
            control_done        = (c == done_cyc);
            user_data_available = (popped < fifo_n) && (!gaps || (c % 2 == 0));
            user_buffer_data    = (popped < fifo_n) ? fifo_data[popped] : 16'd0;
            if (poke && c == 3) begin
                read_en = 1'b1; size = 32'd1; mode = 2'd3; read_addr = 32'h40;
            end else begin
                read_en = 1'b0;
            end
            #1;
            pop = user_read_buffer;
            if (c > 1 && control_go) extra_go = 1'b1;
            @(posedge clk);
            #1;
            if (pop) popped++;
        end
        control_done = 1'b0; user_data_available = 1'b0; read_en = 1'b0;
        chk({tag, " valid_cyc"}, 64'(seen),      64'(exp_valid));
        chk({tag, " busy_end"},  64'(busy),      64'(1'b0));
        chk({tag, " result"},    64'(result),    64'(exp_res));
        chk({tag, " overflow"},  64'(overflow),  64'(exp_ovf));
        chk({tag, " length"},    64'(control_read_length), 64'(exp_len));
        chk({tag, " base"},      64'(control_read_base),   64'(addr[21:0]));
        chk({tag, " pops"},      64'(popped),    64'(sz));
        chk({tag, " single_go"}, 64'(extra_go),  64'(1'b0));
        chk({tag, " fixed"},     64'(control_fixed_location), 64'(1'b0));
    endtask

    // Rejected start: error at N+1, no go pulse, busy stays low.
    task automatic reject(input string tag, input logic [31:0] addr, input logic [31:0] sz);
        read_addr = addr; size = sz; mode = 2'd0; read_en = 1'b1;
        tick();
        read_en = 1'b0;
        chk({tag, " error"}, 64'(error),        64'(1'b1));
        chk({tag, " go"},    64'(control_go),   64'(1'b0));
        chk({tag, " busy"},  64'(busy),         64'(1'b0));
        chk({tag, " rv"},    64'(result_valid), 64'(1'b0));
        tick();
        chk({tag, " go2"},   64'(control_go),   64'(1'b0));
        chk({tag, " busy2"}, 64'(busy),         64'(1'b0));
        chk({tag, " len_hold"}, 64'(control_read_length), 64'(22'd2));
    endtask

    initial begin
        #12;
        chk("rst result", 64'(result),              64'(32'd0));
        chk("rst rv",     64'(result_valid),        64'(1'b0));
        chk("rst busy",   64'(busy),                64'(1'b0));
        chk("rst ovf",    64'(overflow),            64'(1'b0));
        chk("rst err",    64'(error),               64'(1'b0));
        chk("rst base",   64'(control_read_base),   64'(22'd0));
        chk("rst len",    64'(control_read_length), 64'(22'd0));
        chk("rst go",     64'(control_go),          64'(1'b0));
        chk("rst pop",    64'(user_read_buffer),    64'(1'b0));
        rst = 1'b0;
        tick();

        load4(16'd1, 16'd2, 16'd3, 16'd4, 4);
        run_op("sum", 32'h100, 32'd4, 2'd0, 1'b0, 0, 1'b0, 32'd10, 1'b0, 22'd8);

        load4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 3);
        run_op("sq", 32'h200, 32'd3, 2'd1, 1'b1, 0, 1'b0, 32'hFFFA0003, 1'b1, 22'd6);

        load4(16'd7, 16'h8000, 16'd3, 16'd0, 3);
        run_op("max", 32'h300, 32'd3, 2'd2, 1'b0, -3, 1'b0, 32'h00008000, 1'b0, 22'd6);

        load4(16'd7, 16'h8000, 16'd3, 16'd0, 3);
        run_op("min", 32'h302, 32'd3, 2'd3, 1'b0, 0, 1'b0, 32'd3, 1'b0, 22'd6);

        load4(16'hFFFF, 16'd0, 16'd0, 16'd0, 1);
        run_op("min1", 32'h400, 32'd1, 2'd3, 1'b0, 0, 1'b0, 32'h0000FFFF, 1'b0, 22'd2);

        reject("rej size0", 32'h100, 32'd0);
        reject("rej long",  32'h100, 32'h00200000);
        reject("rej align", 32'h101, 32'd4);

        load4(16'd5, 16'd6, 16'd7, 16'd8, 6);
        run_op("early_done", 32'h500, 32'd4, 2'd0, 1'b0, -2, 1'b0, 32'd26, 1'b0, 22'd8);

        load4(16'h10, 16'h20, 16'h30, 16'h40, 4);
        run_op("late_done", 32'h600, 32'd3, 2'd0, 1'b0, 10, 1'b1, 32'h60, 1'b0, 22'd6);

        // Reset in the middle of DRAIN.
        read_addr = 32'h700; size = 32'd4; mode = 2'd0; read_en = 1'b1;
        tick();
        read_en = 1'b0;
        tick();
        tick();
        user_data_available = 1'b1;
        user_buffer_data = 16'd1;
        rst = 1'b1;
        #1;
        chk("mid rst busy",   64'(busy),                64'(1'b0));
        chk("mid rst result", 64'(result),              64'(32'd0));
        chk("mid rst rv",     64'(result_valid),        64'(1'b0));
        chk("mid rst base",   64'(control_read_base),   64'(22'd0));
        chk("mid rst len",    64'(control_read_length), 64'(22'd0));
        chk("mid rst pop",    64'(user_read_buffer),    64'(1'b0));
        user_data_available = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        load4(16'd1, 16'd2, 16'd3, 16'd4, 4);
        run_op("post_rst", 32'h100, 32'd4, 2'd0, 1'b0, 0, 1'b0, 32'd10, 1'b0, 22'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
